elastic_pipe_register: RTL

//  Parametrised successor of the single load-enable register: a DEPTH-stage chain of WIDTH-bit

---
 rtl/pipe_pkg.sv | 17 +
 rtl/elastic_pipe_register_if.sv | 29 ++
 rtl/elastic_pipe_stage.sv | 44 ++++
 rtl/elastic_pipe_register.sv | 95 +++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// ============================================================================
// Module      : pipe_pkg
// Description : Shared helpers for the elastic pipeline register.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pipe_pkg;

  // Counter width that can represent every value from 0 to depth.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/elastic_pipe_register_if.sv
// ============================================================================
// Module      : elastic_pipe_register_if
// Description : Upstream and downstream valid/ready handshake bundle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface elastic_pipe_register_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

`default_nettype wire

// File: rtl/elastic_pipe_stage.sv
// ============================================================================
// Module      : elastic_pipe_stage
// Description : One data/valid register stage with its link in the ready chain.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module elastic_pipe_stage #(
  parameter int WIDTH = 32
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             flush,
  input  wire logic             en,
  input  wire logic [WIDTH-1:0] rst_value,
  input  wire logic             src_valid,
  input  wire logic [WIDTH-1:0] src_data,
  input  wire logic             rdy_in,
  output logic                  valid_q,
  output logic [WIDTH-1:0]      data_q,
  output logic                  rdy_out
);

  logic             r_valid;
  logic [WIDTH-1:0] r_data;

  // An empty stage can always absorb, which is what collapses bubbles.
  assign rdy_out = !r_valid | rdy_in;
  assign valid_q = r_valid;
  assign data_q  = r_data;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_valid <= 1'b0;
      r_data  <= rst_value;
    end else if (en && rdy_out) begin
      r_valid <= src_valid;
      r_data  <= src_data;
    end
  end

endmodule

`default_nettype wire

// File: rtl/elastic_pipe_register.sv
// ============================================================================
// Module      : elastic_pipe_register
// Description : DEPTH-stage elastic register chain with occupancy count.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module elastic_pipe_register
  import pipe_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 3,
  localparam int CNT_W = cnt_width(DEPTH)
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             flush,
  input  wire logic             en,
  input  wire logic [WIDTH-1:0] rst_value,
  elastic_pipe_register_if.slave bus,
  output logic [CNT_W-1:0]      occupancy
);

  localparam logic [CNT_W-1:0] c_one = CNT_W'(1);

  if (DEPTH < 1) begin : g_depth_check
    $error("elastic_pipe_register: DEPTH must be >= 1");
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
    logic             w_src_valid;
    logic [WIDTH-1:0] w_src_data;
    logic             w_rdy_in;
    logic             w_valid_q;
    logic [WIDTH-1:0] w_data_q;
    logic             w_rdy_out;

    if (gi == 0) begin : g_head
      assign w_src_valid = bus.in_valid;
      assign w_src_data  = bus.in_data;
    end else begin : g_body
      assign w_src_valid = g_stage[gi-1].w_valid_q;
      assign w_src_data  = g_stage[gi-1].w_data_q;
    end

    if (gi == DEPTH - 1) begin : g_tail
      assign w_rdy_in = bus.out_ready;
    end else begin : g_mid
      assign w_rdy_in = g_stage[gi+1].w_rdy_out;
    end

    elastic_pipe_stage #(
      .WIDTH (WIDTH)
    ) u_stage (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .en        (en),
      .rst_value (rst_value),
      .src_valid (w_src_valid),
      .src_data  (w_src_data),
      .rdy_in    (w_rdy_in),
      .valid_q   (w_valid_q),
      .data_q    (w_data_q),
      .rdy_out   (w_rdy_out)
    );
  end

  logic             w_in_fire;
  logic             w_out_fire;
  logic [CNT_W-1:0] r_occ;

  assign bus.in_ready  = en & g_stage[0].w_rdy_out;
  assign bus.out_valid = en & g_stage[DEPTH-1].w_valid_q;
  assign bus.out_data  = g_stage[DEPTH-1].w_data_q;
  assign w_in_fire     = bus.in_valid & bus.in_ready;
  assign w_out_fire    = bus.out_valid & bus.out_ready;
  assign occupancy     = r_occ;

  // Both fires carry en, so a frozen chain leaves the count alone.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_occ <= '0;
    end else begin
      case ({w_in_fire, w_out_fire})
        2'b10:   r_occ <= r_occ + c_one;
        2'b01:   r_occ <= r_occ - c_one;
        default: r_occ <= r_occ;
      endcase
    end
  end

endmodule

`default_nettype wire
